router_output_arbiter: RTL

//  Round-robin switch allocator and output register for one router output port.

---
 rtl/router_output_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/router_output_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : router_output_arbiter                                            |
// | Desc    : Round-robin allocator + registered valid/ready output for one    |
// |           router output port, with a stall alarm for blocked downstream.   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module router_output_arbiter #(
    parameter int NUM_PORTS   = 5,
    parameter int DATA_WIDTH  = 32,
    parameter int STALL_LIMIT = 16,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS-1:0]            req_valid,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_packet,
    output logic [NUM_PORTS-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]           out_packet,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_PORTS-1:0]            last_grant,
    output logic                            stall_alarm
);

    localparam int c_PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX   = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] c_STALL_LIM = CNT_WIDTH'(STALL_LIMIT);
    localparam logic [c_PTR_W-1:0]   c_LAST_IDX  = c_PTR_W'(NUM_PORTS - 1);

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [DATA_WIDTH-1:0]   r_out_packet;
    logic [NUM_PORTS-1:0]    r_last_grant;
    logic [c_PTR_W-1:0]      r_rr_ptr;
    logic [CNT_WIDTH-1:0]    r_stall_cnt;
    logic                    r_stall_alarm;

    logic                    w_can_accept;
    logic                    w_found;
    logic [c_PTR_W-1:0]      w_win;
    logic [NUM_PORTS-1:0]    w_win_oh;
    logic [DATA_WIDTH-1:0]   w_win_pkt;
    logic                    w_accept;
    logic [c_PTR_W-1:0]      w_ptr_nxt;
    logic                    w_blocked;
    logic [CNT_WIDTH-1:0]    w_cnt_nxt;

    assign out_valid    = (r_state == S_FULL);
    assign w_can_accept = !out_valid || out_ready;

    // Two descending passes, last hit wins: indices at/above the pointer take
    // precedence over the wrapped-around indices below it.
    always_comb begin
        w_found   = 1'b0;
        w_win     = '0;
        w_win_oh  = '0;
        w_win_pkt = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (req_valid[i] && (c_PTR_W'(i) < r_rr_ptr)) begin
                w_found     = 1'b1;
                w_win       = c_PTR_W'(i);
                w_win_oh    = '0;
                w_win_oh[i] = 1'b1;
                w_win_pkt   = req_packet[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (req_valid[i] && (c_PTR_W'(i) >= r_rr_ptr)) begin
                w_found     = 1'b1;
                w_win       = c_PTR_W'(i);
                w_win_oh    = '0;
                w_win_oh[i] = 1'b1;
                w_win_pkt   = req_packet[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_accept  = w_can_accept && w_found;
    assign req_ready = w_accept ? w_win_oh : '0;
    assign w_ptr_nxt = (w_win == c_LAST_IDX) ? '0 : w_win + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            w_state_nxt = S_FULL;
        end else if (r_state == S_FULL && out_ready) begin
            w_state_nxt = S_EMPTY;
        end
    end

    assign w_blocked = out_valid && !out_ready;

    always_comb begin
        w_cnt_nxt = '0;
        if (w_blocked) begin
            w_cnt_nxt = (r_stall_cnt == c_CNT_MAX) ? r_stall_cnt : r_stall_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_EMPTY;
            r_out_packet  <= '0;
            r_last_grant  <= '0;
            r_rr_ptr      <= '0;
            r_stall_cnt   <= '0;
            r_stall_alarm <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_out_packet <= w_win_pkt;
                r_last_grant <= w_win_oh;
                r_rr_ptr     <= w_ptr_nxt;
            end
            r_stall_cnt   <= w_cnt_nxt;
            r_stall_alarm <= (w_cnt_nxt >= c_STALL_LIM);
        end
    end

    assign out_packet  = r_out_packet;
    assign last_grant  = r_last_grant;
    assign stall_alarm = r_stall_alarm;

endmodule
`default_nettype wire
